// File: rtl/upg_program_loader_pkg.sv
// Shared definitions for the UART program loader.
//   state_t         : loader FSM encoding (3 bits)
//   CHK_SEED        : initial value of the running XOR checksum
//   upg_max_words() : largest legal image length for a given ROM address width
package upg_program_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_LO = 3'd1,
    ST_LEN_HI = 3'd2,
    ST_DATA   = 3'd3,
    ST_CHECK  = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERROR  = 3'd6
  } state_t;

  localparam logic [7:0] CHK_SEED = 8'h00;

  function automatic logic [31:0] upg_max_words(input int aw);
    return 32'd1 << aw;
  endfunction

endpackage

// File: rtl/upg_timeout_counter.sv
// Inter-byte idle timer for the program loader.
//   iClock/iResetN : clock, async active-low reset
//   clear          : restart the count at zero (wins over enable)
//   enable         : count one cycle
//   expired        : count has reached TIMEOUT_CYCLES-1; holds there until cleared
module upg_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 10_000_000
) (
  input  logic iClock,
  input  logic iResetN,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt;

  assign expired = (cnt == LAST);

  always_ff @(posedge iClock or negedge iResetN) begin
    if (!iResetN)               cnt <= '0;
    else if (clear)             cnt <= '0;
    else if (enable && !expired) cnt <= cnt + CW'(1);
  end

endmodule

// File: rtl/upg_program_loader.sv
// UART programming sequencer for the program ROM.
// Frame: len_lo, len_hi (word count N), 4*N data bytes (little-endian words),
// then one XOR checksum byte covering every preceding byte of the frame.
//   iClock, iResetN        : clock, async active-low reset
//   iStart                 : pulse, (re)arm the loader; beats a coincident byte
//   iRxValid, iRxData      : received byte strobe / byte
//   oBusy                  : frame in progress
//   oUpgWriteEnable        : one-cycle ROM write strobe
//   oUpgWriteAddress/Data  : word address / word for the current strobe
//   oUpgDone, oError       : sticky result flags (mutually exclusive)
module upg_program_loader
  import upg_program_loader_pkg::*;
#(
  parameter int ADDR_WIDTH     = 14,
  parameter int TIMEOUT_CYCLES = 10_000_000
) (
  input  logic                  iClock,
  input  logic                  iResetN,
  input  logic                  iStart,
  input  logic                  iRxValid,
  input  logic [7:0]            iRxData,
  output logic                  oBusy,
  output logic                  oUpgWriteEnable,
  output logic [ADDR_WIDTH-1:0] oUpgWriteAddress,
  output logic [31:0]           oUpgWriteData,
  output logic                  oUpgDone,
  output logic                  oError
);

  localparam logic [31:0] MAX_WORDS = upg_max_words(ADDR_WIDTH);

  state_t      state, state_nxt;
  logic [7:0]  len_lo;
  logic [15:0] len;
  logic [1:0]  byte_idx;
  logic [23:0] word_acc;
  logic [7:0]  chk;
  logic        expired;

  logic        rx_acc;
  logic [15:0] len_n;
  logic        len_bad;
  logic        last_word;

  assign rx_acc  = iRxValid && !iStart;
  assign len_n   = {iRxData, len_lo};
  assign len_bad = (len_n == 16'd0) || (32'(len_n) > MAX_WORDS);
  // The final word's strobe cycle still belongs to DATA; a byte arriving in
  // that same cycle is already the checksum byte.
  assign last_word = oUpgWriteEnable &&
                     ((32'(oUpgWriteAddress) + 32'd1) == 32'(len));

  assign oBusy    = (state == ST_LEN_LO) || (state == ST_LEN_HI) ||
                    (state == ST_DATA)   || (state == ST_CHECK);
  assign oUpgDone = (state == ST_DONE);
  assign oError   = (state == ST_ERROR);

  upg_timeout_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .iClock  (iClock),
    .iResetN (iResetN),
    .clear   (iStart || rx_acc || !oBusy),
    .enable  (oBusy),
    .expired (expired)
  );

  always_ff @(posedge iClock or negedge iResetN) begin
    if (!iResetN) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (iStart) begin
      state_nxt = ST_LEN_LO;
    end else begin
      case (state)
        ST_LEN_LO: begin
          if (rx_acc)       state_nxt = ST_LEN_HI;
          else if (expired) state_nxt = ST_ERROR;
        end
        ST_LEN_HI: begin
          if (rx_acc)       state_nxt = len_bad ? ST_ERROR : ST_DATA;
          else if (expired) state_nxt = ST_ERROR;
        end
        ST_DATA: begin
          if (last_word) begin
            if (rx_acc) state_nxt = (iRxData == chk) ? ST_DONE : ST_ERROR;
            else        state_nxt = ST_CHECK;
          end else if (!rx_acc && expired) begin
            state_nxt = ST_ERROR;
          end
        end
        ST_CHECK: begin
          if (rx_acc)       state_nxt = (iRxData == chk) ? ST_DONE : ST_ERROR;
          else if (expired) state_nxt = ST_ERROR;
        end
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge iClock or negedge iResetN) begin
    if (!iResetN) begin
      oUpgWriteEnable  <= 1'b0;
      oUpgWriteAddress <= '0;
      oUpgWriteData    <= '0;
      len_lo           <= '0;
      len              <= '0;
      byte_idx         <= '0;
      word_acc         <= '0;
      chk              <= CHK_SEED;
    end else begin
      oUpgWriteEnable <= 1'b0;
      if (iStart) begin
        oUpgWriteAddress <= '0;
        byte_idx         <= '0;
        chk              <= CHK_SEED;
      end else begin
        // Address moves only after its strobe cycle has completed.
        if (oUpgWriteEnable) oUpgWriteAddress <= oUpgWriteAddress + 1'b1;

        if (rx_acc && state == ST_LEN_LO) begin
          len_lo <= iRxData;
          chk    <= chk ^ iRxData;
        end

        if (rx_acc && state == ST_LEN_HI) begin
          len <= len_n;
          chk <= chk ^ iRxData;
        end

        if (rx_acc && state == ST_DATA && !last_word) begin
          chk      <= chk ^ iRxData;
          byte_idx <= byte_idx + 2'd1;
          case (byte_idx)
            2'd0: word_acc[7:0]   <= iRxData;
            2'd1: word_acc[15:8]  <= iRxData;
            2'd2: word_acc[23:16] <= iRxData;
            default: begin
              oUpgWriteData   <= {iRxData, word_acc};
              oUpgWriteEnable <= 1'b1;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_upg_program_loader.sv
module tb_upg_program_loader;

  localparam int AW = 14;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          busy;
  logic          we;
  logic [AW-1:0] waddr;
  logic [31:0]   wdata;
  logic          done;
  logic          err;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [31:0]   d;
  } wr_t;

  wr_t        exp_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] run_chk;

  always #5 clk = ~clk;

  upg_program_loader #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .iClock           (clk),
    .iResetN          (rst_n),
    .iStart           (start),
    .iRxValid         (rx_valid),
    .iRxData          (rx_data),
    .oBusy            (busy),
    .oUpgWriteEnable  (we),
    .oUpgWriteAddress (waddr),
    .oUpgWriteData    (wdata),
    .oUpgDone         (done),
    .oError           (err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && we === 1'b1) begin
      wr_t e;
      check("strobe_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("wr_addr", 32'(waddr), 32'(e.a));
        check("wr_data", wdata, e.d);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    run_chk = 8'h00;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    run_chk  = run_chk ^ b;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic send_chk(input logic [7:0] flip);
    send_byte(run_chk ^ flip);
  endtask

  task automatic expect_wr(input int a, input logic [31:0] d);
    wr_t e;
    e.a = AW'(a);
    e.d = d;
    exp_q.push_back(e);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; run_chk = 8'h00;
    tick(); tick();
    check("rst_busy", 32'(busy), 0);
    check("rst_we",   32'(we), 0);
    check("rst_addr", 32'(waddr), 0);
    check("rst_data", wdata, 0);
    check("rst_done", 32'(done), 0);
    check("rst_err",  32'(err), 0);
    rst_n = 1'b1;
    tick();

    // 1: good two-word frame, checksum right behind the last data byte
    pulse_start();
    check("t1_busy", 32'(busy), 1);
    expect_wr(0, 32'h12345678);
    expect_wr(1, 32'hDEADBEEF);
    send_byte(8'h02); send_byte(8'h00);
    send_word(32'h12345678); send_word(32'hDEADBEEF);
    send_chk(8'h00);
    tick();
    check("t1_done", 32'(done), 1);
    check("t1_busy_end", 32'(busy), 0);
    check("t1_err", 32'(err), 0);
    check("t1_q_empty", 32'(exp_q.size()), 0);

    // 2: same frame, corrupted checksum, with idle gap before it
    pulse_start();
    check("t2_done_cleared", 32'(done), 0);
    expect_wr(0, 32'h12345678);
    expect_wr(1, 32'hDEADBEEF);
    send_byte(8'h02); send_byte(8'h00);
    send_word(32'h12345678); send_word(32'hDEADBEEF);
    tick(); tick();
    check("t2_in_check", 32'(busy), 1);
    send_chk(8'h01);
    tick();
    check("t2_err", 32'(err), 1);
    check("t2_done", 32'(done), 0);
    check("t2_q_empty", 32'(exp_q.size()), 0);

    // 3: illegal and boundary lengths
    pulse_start();
    check("t3_err_cleared", 32'(err), 0);
    send_byte(8'h00); send_byte(8'h00);
    check("t3_len0_err", 32'(err), 1);
    pulse_start();
    send_byte(8'h01); send_byte(8'h40);
    check("t3_len4001_err", 32'(err), 1);
    pulse_start();
    send_byte(8'h00); send_byte(8'h40);
    check("t3_len4000_ok", 32'(err), 0);
    check("t3_len4000_busy", 32'(busy), 1);

    // 4: stall mid-word; error after exactly TO idle edges
    pulse_start();
    send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h11); send_byte(8'h22);
    for (int i = 0; i < TO - 1; i++) tick();
    check("t4_not_yet", 32'(err), 0);
    tick();
    check("t4_timeout", 32'(err), 1);
    check("t4_busy", 32'(busy), 0);

    // 5: restart mid-DATA with a coincident byte that must be dropped
    pulse_start();
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'hAA); send_byte(8'hBB);
    start = 1'b1; rx_valid = 1'b1; rx_data = 8'hCC;
    tick();
    start = 1'b0; rx_valid = 1'b0; run_chk = 8'h00;
    expect_wr(0, 32'h11223344);
    send_byte(8'h01); send_byte(8'h00);
    send_word(32'h11223344);
    send_chk(8'h00);
    tick();
    check("t5_done", 32'(done), 1);
    check("t5_q_empty", 32'(exp_q.size()), 0);

    // 6: reset between 3rd and 4th data byte
    pulse_start();
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
    rst_n = 1'b0;
    #1;
    check("t6_busy_rst", 32'(busy), 0);
    check("t6_done_rst", 32'(done), 0);
    check("t6_err_rst",  32'(err), 0);
    check("t6_addr_rst", 32'(waddr), 0);
    tick();
    rst_n = 1'b1;
    send_byte(8'h04);
    tick(); tick();
    check("t6_idle", 32'(busy), 0);
    check("t6_no_done", 32'(done), 0);
    check("t6_q_empty", 32'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
